fence_sequencer: RTL

Pipeline-side controller that turns FENCE and FENCE.I requests into the ordered cache-control sequence on the cache-control interface, and stalls the pipeline until the caches report completion. It sits between the execute/commit stage and the I/D caches. It drives `icache_clear`, `icache_flush`, `dcache_clear` and `dcache_flush`, and consumes `iclear_done`, `iflush_done`, `dclear_done` and `dflush_done`.

---
 rtl/fence_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fence_sequencer.sv
// fence_sequencer: turns FENCE / FENCE.I requests into the ordered
// dcache-flush / icache-clear sequence and stalls the pipeline meanwhile.
module fence_sequencer #(
  parameter bit DCACHE_WRITEBACK = 1'b1,
  parameter int CNT_W            = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             fence_req,
  input  logic             fence_i_req,
  output logic             fence_stall,
  output logic             fence_ack,
  output logic [CNT_W-1:0] last_fence_cycles,
  output logic             dcache_flush,
  output logic             dcache_clear,
  output logic             icache_clear,
  output logic             icache_flush,
  input  logic             dflush_done,
  input  logic             dclear_done,
  input  logic             iclear_done,
  input  logic             iflush_done
);

  typedef enum logic [1:0] {
    IDLE,
    DFLUSH,
    ICLEAR,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             is_fi_q, is_fi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             dfl_q, icl_q, ack_q;
  logic             unused_done;

  // The clear/flush-of-other-cache handshakes are reserved, never driven.
  assign unused_done = dclear_done | iflush_done;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + ONE;

  // Next-state, request latch and fence-duration bookkeeping.
  always_comb begin
    state_d = state_q;
    is_fi_d = is_fi_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (fence_i_req) begin
          is_fi_d = 1'b1;
          state_d = DCACHE_WRITEBACK ? DFLUSH : ICLEAR;
        end else if (fence_req) begin
          is_fi_d = 1'b0;
          state_d = DFLUSH;
        end
      end
      DFLUSH: begin
        cnt_d = cnt_inc;
        if (dflush_done) begin
          state_d = is_fi_q ? ICLEAR : DONE;
        end
      end
      ICLEAR: begin
        cnt_d = cnt_inc;
        if (iclear_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // The final busy cycle counts toward the reported duration.
    if (state_d == DONE && state_q != DONE) begin
      last_d = cnt_inc;
      cnt_d  = '0;
    end
  end

  // State, counters and glitch-free registered cache controls.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      is_fi_q <= 1'b0;
      cnt_q   <= '0;
      last_q  <= '0;
      dfl_q   <= 1'b0;
      icl_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      is_fi_q <= is_fi_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      dfl_q   <= (state_d == DFLUSH);
      icl_q   <= (state_d == ICLEAR);
      ack_q   <= (state_d == DONE);
    end
  end

  assign fence_stall = ~RST & (
    ((state_q == IDLE) & (fence_req | fence_i_req)) |
    (state_q == DFLUSH) | (state_q == ICLEAR));

  assign fence_ack         = ack_q;
  assign dcache_flush      = dfl_q;
  assign icache_clear      = icl_q;
  assign dcache_clear      = 1'b0;
  assign icache_flush      = 1'b0;
  assign last_fence_cycles = last_q;

endmodule
